// File: rtl/acc_snapshot_fifo.sv
// Snapshot FIFO behind the 8-bit accumulator: captures dout on snap with a wrap flag
// (value below the previous snapshot) and hands entries to a reader over valid/ready.
module acc_snapshot_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] acc_in,
    input  logic             snap,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_wrap,
    output logic [AW:0]      level,
    output logic             full,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam logic [AW:0] DepthVal = (AW+1)'(DEPTH);

    logic [WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] prev;
    logic             ovfReg;

    logic isEmpty;
    logic isFull;
    logic doPop;
    logic doPush;
    logic doDrop;
    logic wrapBit;

    // Read side: the head is offered whenever the FIFO holds an entry and it leaves
    // on a clock edge where rd_valid and rd_ready are both high. snap is never stalled;
    // a snapshot arriving while full with no pop in the same cycle is dropped.
    always_comb begin
        isEmpty = (count == '0);
        isFull  = (count == DepthVal);
        doPop   = !isEmpty && rd_ready;
        doPush  = snap && (!isFull || doPop);
        doDrop  = snap && isFull && !doPop;
        wrapBit = (acc_in < prev);
    end

    // Storage carries no reset; the read mux below hides stale contents when empty.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= {wrapBit, acc_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            prev   <= '0;
            ovfReg <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doPush && !doPop) begin
                count <= count + 1'b1;
            end else if (doPop && !doPush) begin
                count <= count - 1'b1;
            end
            // prev tracks every snapshot, including dropped ones.
            if (snap) begin
                prev <= acc_in;
            end
            // A drop in the same cycle as clr_ovf keeps the flag set.
            if (doDrop) begin
                ovfReg <= 1'b1;
            end else if (clr_ovf) begin
                ovfReg <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_valid = !isEmpty;
        rd_data  = '0;
        rd_wrap  = 1'b0;
        if (!isEmpty) begin
            rd_data = mem[rdPtr][WIDTH-1:0];
            rd_wrap = mem[rdPtr][WIDTH];
        end
        level    = count;
        full     = isFull;
        overflow = ovfReg;
    end

endmodule
